// File: rtl/lenet_pkg.sv
// Shared datapath constants and types for the LeNet accelerator.
// Default activation width and the signed sample type used between layers.
package lenet_pkg;

    localparam int DATA_WIDTH = 8;

    typedef logic signed [DATA_WIDTH-1:0] act_t;

endpackage

// File: rtl/relu_core.sv
// Combinational clamp(x, 0, CLIP_MAX) on a signed two's-complement sample.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the output follows the input continuously.
module relu_core
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH = lenet_pkg::DATA_WIDTH,
    parameter int CLIP_MAX   = 2**(DATA_WIDTH-1) - 1
) (
    input  logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] y
);

    localparam logic signed [DATA_WIDTH-1:0] CLIP = DATA_WIDTH'(CLIP_MAX);

    logic signed [DATA_WIDTH-1:0] x_s;
    assign x_s = x;

    // Non-positive inputs are caught first, so the clip compare only sees positive values.
    always_comb begin
        y = '0;
        if (x_s[DATA_WIDTH-1] || (x_s == '0)) begin
            y = '0;
        end else if (x_s > CLIP) begin
            y = CLIP;
        end else begin
            y = x;
        end
    end

endmodule

// File: rtl/relu.sv
// Registered ReLU activation with an optional upper saturation bound.
// Latency: 1 cycle from data_in to data_out; no combinational path through.
// Backpressure: none; one sample is accepted every clock.
module relu
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH = lenet_pkg::DATA_WIDTH,
    parameter int CLIP_MAX   = 2**(DATA_WIDTH-1) - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    if ((DATA_WIDTH < 2) || (CLIP_MAX < 1) || (CLIP_MAX > (2**(DATA_WIDTH-1) - 1))) begin : g_param_check
        $error("relu: illegal DATA_WIDTH=%0d / CLIP_MAX=%0d", DATA_WIDTH, CLIP_MAX);
    end

    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] data_q;

    relu_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .CLIP_MAX   (CLIP_MAX)
    ) u_core (
        .x (data_in),
        .y (data_d)
    );

    // rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: tb/tb_relu.sv
// Bench for relu: default instance and a CLIP_MAX=6 instance share one input stream.
module tb_relu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic [7:0] out_def;
    logic [7:0] out_c6;

    always #5 clk = ~clk;

    relu u_def (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .data_out (out_def)
    );

    relu #(.DATA_WIDTH(8), .CLIP_MAX(6)) u_c6 (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .data_out (out_c6)
    );

    typedef struct {
        int din;
        int exp_def;
        int exp_c6;
    } vec_t;

    typedef struct {
        int  exp_def;
        int  exp_c6;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int ref_relu(input int x, input int clip);
        if (x <= 0)
            return 0;
        else if (x > clip)
            return clip;
        else
            return x;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input int want);
        logic [7:0] w;
        w = 8'(want);
        checks++;
        if (got !== w) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Compare the oldest pending expectation against both outputs.
    task automatic check_out();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, "_def"}, out_def, e.exp_def);
            chk({e.tag, "_c6"},  out_c6,  e.exp_c6);
        end
    endtask

    task automatic step(input int x, input int ed, input int ec, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        check_out();
        e.exp_def = ed;
        e.exp_c6  = ec;
        e.tag     = tag;
        sb.push_back(e);
        data_in = 8'(x);
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        check_out();
    endtask

    vec_t       vecs[14];
    logic [7:0] r;
    int         x;

    initial begin
        vecs[0]  = '{-128, 0,   0};
        vecs[1]  = '{-1,   0,   0};
        vecs[2]  = '{0,    0,   0};
        vecs[3]  = '{1,    1,   1};
        vecs[4]  = '{127,  127, 6};
        vecs[5]  = '{5,    5,   5};
        vecs[6]  = '{-5,   0,   0};
        vecs[7]  = '{5,    5,   5};
        vecs[8]  = '{-5,   0,   0};
        vecs[9]  = '{3,    3,   3};
        vecs[10] = '{6,    6,   6};
        vecs[11] = '{7,    7,   6};
        vecs[12] = '{100,  100, 6};
        vecs[13] = '{-3,   0,   0};

        rst_n   = 1'b0;
        data_in = 8'h55;

        // Assert reset before any clock edge: output must clear asynchronously.
        #2 rst_n = 1'b1;
        #1;
        chk("rst_async_def", out_def, 0);
        chk("rst_async_c6",  out_c6,  0);

        repeat (5) begin
            @(posedge clk);
            #1;
            chk("rst_hold_def", out_def, 0);
            chk("rst_hold_c6",  out_c6,  0);
        end
        rst_n = 1'b0;

        for (int i = -10; i <= 10; i++)
            step(i, ref_relu(i, 127), ref_relu(i, 6), "sweep");
        drain();

        for (int i = 0; i < 14; i++)
            step(vecs[i].din, vecs[i].exp_def, vecs[i].exp_c6, "table");
        drain();

        for (int i = 0; i < 20; i++) begin
            r = 8'($urandom_range(0, 255));
            x = int'($signed(r));
            step(x, ref_relu(x, 127), ref_relu(x, 6), "rand");
        end
        drain();

        // Mid-stream reset while the default output shows 7.
        step(7, 7, 6, "pre_rst");
        drain();
        #3 rst_n = 1'b1;
        #1;
        chk("mid_rst_async_def", out_def, 0);
        chk("mid_rst_async_c6",  out_c6,  0);
        @(posedge clk);
        #1;
        chk("mid_rst_hold_def", out_def, 0);
        chk("mid_rst_hold_c6",  out_c6,  0);
        rst_n = 1'b0;
        sb.push_back('{11, 6, "resume"});
        data_in = 8'(11);
        drain();
        step(-20, 0, 0, "resume2");
        drain();

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
